// File: rtl/decoder_onehot_seq_pkg.sv
// ----------------------------------------------------------------------------
// decoder_onehot_seq_pkg
// Definitions shared by the registered one-hot decoder and its pulse timer.
// Contents:
//   state_t    - decoder state encoding (IDLE = 0, HOLD = 1, PULSE = 2)
//   MODE_LEVEL - in_mode value that requests a level-hold output
//   MODE_PULSE - in_mode value that requests a timed pulse output
// No ports (package).
// ----------------------------------------------------------------------------
package decoder_onehot_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        PULSE = 2'd2
    } state_t;

    localparam logic MODE_LEVEL = 1'b0;
    localparam logic MODE_PULSE = 1'b1;

endpackage

// File: rtl/decoder_pulse_timer.sv
// ----------------------------------------------------------------------------
// decoder_pulse_timer
// Down-counter that times how long a pulse-mode output stays asserted.
// A load presets the counter to PULSE_LEN-1, and done is high while the
// counter is zero. The counter therefore reads zero during the final pulse
// cycle. It stops at zero and never wraps.
// Ports:
//   clk   in  system clock
//   rst   in  synchronous active-high reset (counter -> 0)
//   clr   in  synchronous soft clear (counter -> 0)
//   load  in  preset counter to PULSE_LEN-1
//   count in  decrement while non-zero
//   done  out counter is zero
// ----------------------------------------------------------------------------
module decoder_pulse_timer #(
    parameter int unsigned PULSE_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic load,
    input  logic count,
    output logic done
);

    localparam int unsigned CW = $clog2(PULSE_LEN + 1);

    logic [CW-1:0] cnt;

    // Counter register. Reset and clear both return it to zero.
    // A load wins over counting. Counting saturates at zero, so a stray
    // count request can never wrap the counter around.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CW'(PULSE_LEN - 1);
        end else if (count && (cnt != '0)) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/decoder_onehot_seq.sv
// ----------------------------------------------------------------------------
// decoder_onehot_seq
// Registered, parametrised binary-to-one-hot decoder with a valid/ready input.
// Each accepted code either holds its output bit (level mode) or asserts it
// for PULSE_LEN cycles (pulse mode). Codes >= OUT_W produce a one-cycle err
// and leave the output idle. With ACTIVE_LOW set, the whole bus is inverted.
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   clr        in   synchronous soft clear back to IDLE (blocks accepts)
//   in_valid   in   in_code/in_mode are offered
//   in_ready   out  block can accept this cycle
//   in_code    in   binary code to decode (IN_W bits)
//   in_mode    in   0 = level-hold, 1 = timed pulse
//   out        out  registered one-hot decode (OUT_W bits)
//   out_active out  an output bit is currently asserted
//   err        out  one-cycle flag after an out-of-range accept
// ----------------------------------------------------------------------------
module decoder_onehot_seq
    import decoder_onehot_seq_pkg::*;
#(
    parameter int unsigned IN_W       = 3,
    parameter int unsigned OUT_W      = 8,
    parameter int unsigned PULSE_LEN  = 4,
    parameter bit          ACTIVE_LOW = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_code,
    input  logic             in_mode,
    output logic [OUT_W-1:0] out,
    output logic             out_active,
    output logic             err
);

    // Value of the output bus when nothing is asserted. XOR-ing the
    // active-high decode with this yields the optional inversion.
    localparam logic [OUT_W-1:0] OUT_IDLE = {OUT_W{ACTIVE_LOW}};

    state_t            state_q;
    state_t            state_d;
    logic [IN_W-1:0]   code_q;
    logic [IN_W-1:0]   code_d;
    logic [OUT_W-1:0]  out_d;
    logic              err_q;
    logic              err_d;
    logic              accept;
    logic              in_range;
    logic              timer_load;
    logic              timer_count;
    logic              timer_done;

    // A pulse in flight blocks new input until the pulse has finished.
    // A soft clear also blocks it, so a clr cycle can never accept.
    assign in_ready = !clr && (state_q != PULSE);
    assign accept   = in_valid && in_ready;

    // The compare is widened to 32 bits so that it stays legal even when
    // OUT_W == 2**IN_W, which makes it always true.
    assign in_range = (32'(in_code) < OUT_W);

    decoder_pulse_timer #(
        .PULSE_LEN (PULSE_LEN)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .load  (timer_load),
        .count (timer_count),
        .done  (timer_done)
    );

    // Next-state logic. IDLE and HOLD both accept. An in-range code selects
    // HOLD or PULSE from in_mode, and an out-of-range code drops to IDLE
    // with err. PULSE leaves once the timer reports its last cycle. clr
    // overrides all of this and forces IDLE.
    always_comb begin
        state_d     = state_q;
        code_d      = code_q;
        err_d       = 1'b0;
        timer_load  = 1'b0;
        timer_count = 1'b0;

        case (state_q)
            IDLE, HOLD: begin
                if (accept) begin
                    if (in_range) begin
                        code_d = in_code;
                        if (in_mode == MODE_PULSE) begin
                            state_d    = PULSE;
                            timer_load = 1'b1;
                        end else begin
                            state_d = HOLD;
                        end
                    end else begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end
                end
            end
            PULSE: begin
                timer_count = 1'b1;
                if (timer_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (clr) begin
            state_d    = IDLE;
            err_d      = 1'b0;
            timer_load = 1'b0;
        end
    end

    // One-hot decode of the next code. It is computed from next-state
    // values, so the registered bus changes on the same edge as the state.
    // A back-to-back replace therefore never shows an idle gap.
    always_comb begin
        out_d = '0;
        for (int unsigned k = 0; k < OUT_W; k++) begin
            out_d[k] = (state_d != IDLE) && (32'(code_d) == k);
        end
    end

    // State, code, output and error registers. Reset returns everything
    // to idle, and an inverted bus resets to all ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            code_q  <= '0;
            out     <= OUT_IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            out     <= out_d ^ OUT_IDLE;
            err_q   <= err_d;
        end
    end

    assign out_active = (state_q != IDLE);
    assign err        = err_q;

endmodule
